// File: rtl/apb_slave_regfile.sv
// APB slave register file: register 0 is a read-only ID, the rest are 32-bit R/W.
// Fixed, parameterised wait states, with error response on misaligned, out-of-range or ID writes.
module apb_slave_regfile #(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] PADDR,
   input  logic        PSELx,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic        PREADY,
   output logic [31:0] PRDATA,
   output logic        PSLVERR,
   output logic        state_dbg
);

   localparam int IDX_W = $clog2(NUM_REGS);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [3:0]         cnt;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic               write_q;
   logic [31:0]        regs [NUM_REGS];

   logic               latch_en;
   logic               cnt_dec;
   logic               commit;
   logic               err;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        rdata;

   // Handshake: the requester presents a setup cycle (PSELx=1, PENABLE=0), then
   // holds PSELx=PENABLE=1; the transfer completes on the edge where PREADY=1.
   // Request fields are captured at setup and ignored for the rest of the transfer.
   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_en  = 1'b0;
      cnt_dec   = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (PSELx && !PENABLE) begin
               latch_en  = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (PSELx && PENABLE) begin
               if (cnt != 4'd0) begin
                  cnt_dec = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  commit    = write_q && !err;
               end
            end else if (PSELx) begin
               // A fresh setup phase in place of an access cycle restarts the transfer.
               latch_en  = 1'b1;
               state_nxt = ACCESS;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign idx   = addr_q[IDX_W+1:2];
   assign err   = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * NUM_REGS)) ||
                  (write_q && (idx == '0));
   assign rdata = (idx == '0) ? ID_VALUE : regs[idx];

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt     <= 4'd0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         write_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
      end else begin
         if (latch_en) begin
            cnt     <= 4'(WAIT_STATES);
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
         end else if (cnt_dec) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) regs[idx] <= wdata_q;
      end
   end

   assign PREADY    = (state == ACCESS) && (cnt == 4'd0);
   assign PSLVERR   = PREADY && err;
   assign PRDATA    = (PREADY && !write_q && !err) ? rdata : 32'h0;
   assign state_dbg = (state == ACCESS);

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with one wait state, one with none,
// sharing a single APB bus; each transfer waits on the selected instance's PREADY.
module tb_apb_slave_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;

   logic        pready_s, pslverr_s, state_s;
   logic [31:0] prdata_s;
   logic        pready_f, pslverr_f, state_f;
   logic [31:0] prdata_f;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rd;
   logic        er;
   int          wt;

   apb_slave_regfile u_slow (
      .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSELx(psel), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready_s), .PRDATA(prdata_s),
      .PSLVERR(pslverr_s), .state_dbg(state_s)
   );

   apb_slave_regfile #(.WAIT_STATES(0)) u_fast (
      .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSELx(psel), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready_f), .PRDATA(prdata_f),
      .PSLVERR(pslverr_f), .state_dbg(state_f)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         psel    = 1'b0;
         penable = 1'b0;
      end
   endtask

   // One complete transfer; returns after sampling the completing cycle so a
   // following call issues its setup phase in the very next cycle.
   task automatic apb_xfer(input bit fast, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] rdata,
                           output logic err, output int waits);
      bit done;
      waits = 0;
      done  = 1'b0;
      rdata = 32'h0;
      err   = 1'b0;
      @(posedge clk); #1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      @(posedge clk); #1;
      penable = 1'b1;
      // Request fields must have been captured at setup; scramble them now.
      pwrite  = ~wr;
      paddr   = addr ^ 32'h4;
      pwdata  = ~data;
      for (int i = 0; i < 16 && !done; i++) begin
         @(negedge clk);
         if ((fast ? pready_f : pready_s) === 1'b1) begin
            rdata = fast ? prdata_f : prdata_s;
            err   = fast ? pslverr_f : pslverr_s;
            done  = 1'b1;
         end else begin
            if ((fast ? pslverr_f : pslverr_s) !== 1'b0) check("pslverr_while_wait", 32'h1, 32'h0);
            waits++;
            @(posedge clk); #1;
         end
      end
      if (!done) check("pready_timeout", 32'h0, 32'h1);
   endtask

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'h0; pwdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pready", {31'h0, pready_s}, 32'h0);
      check("rst_prdata", prdata_s, 32'h0);
      check("rst_pslverr", {31'h0, pslverr_s}, 32'h0);
      check("rst_state", {31'h0, state_s}, 32'h0);
      @(posedge clk); #1; rst = 1'b0;

      // Basic write/read with one wait state
      apb_xfer(1'b0, 1'b1, 32'h04, 32'h1234_5678, rd, er, wt);
      check("wr04_waits", 32'(wt), 32'd1);
      check("wr04_err", {31'h0, er}, 32'h0);
      apb_xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, er, wt);
      check("rd04_waits", 32'(wt), 32'd1);
      check("rd04_data", rd, 32'h1234_5678);
      check("rd04_err", {31'h0, er}, 32'h0);

      // ID register is read-only
      apb_xfer(1'b0, 1'b0, 32'h00, 32'h0, rd, er, wt);
      check("rd00_id", rd, 32'hA5B0_0001);
      check("rd00_err", {31'h0, er}, 32'h0);
      apb_xfer(1'b0, 1'b1, 32'h00, 32'hFFFF_FFFF, rd, er, wt);
      check("wr00_err", {31'h0, er}, 32'h1);
      apb_xfer(1'b0, 1'b0, 32'h00, 32'h0, rd, er, wt);
      check("rd00_again", rd, 32'hA5B0_0001);

      // Out of range and misaligned
      apb_xfer(1'b0, 1'b0, 32'h40, 32'h0, rd, er, wt);
      check("rd40_err", {31'h0, er}, 32'h1);
      check("rd40_data", rd, 32'h0);
      apb_xfer(1'b0, 1'b1, 32'h06, 32'hDEAD_BEEF, rd, er, wt);
      check("wr06_err", {31'h0, er}, 32'h1);
      apb_xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, er, wt);
      check("rd04_after_err", rd, 32'h1234_5678);
      apb_xfer(1'b0, 1'b0, 32'h00000044, 32'h0, rd, er, wt);
      check("rd44_err", {31'h0, er}, 32'h1);

      // Abort mid-wait: PSELx dropped before completion
      apb_xfer(1'b0, 1'b1, 32'h08, 32'hCAFE_0008, rd, er, wt);
      bus_idle(1);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hBAD0_0008;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("abort_wait_pready", {31'h0, pready_s}, 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      check("abort_state", {31'h0, state_s}, 32'h0);
      check("abort_pready", {31'h0, pready_s}, 32'h0);
      apb_xfer(1'b0, 1'b0, 32'h08, 32'h0, rd, er, wt);
      check("rd08_after_abort", rd, 32'hCAFE_0008);

      // Reset during the wait cycle of a write
      bus_idle(1);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      penable = 1'b1;
      rst     = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      check("rst_mid_pready", {31'h0, pready_s}, 32'h0);
      check("rst_mid_prdata", prdata_s, 32'h0);
      check("rst_mid_pslverr", {31'h0, pslverr_s}, 32'h0);
      apb_xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, er, wt);
      check("rd04_after_rst", rd, 32'h0);
      apb_xfer(1'b0, 1'b0, 32'h08, 32'h0, rd, er, wt);
      check("rd08_after_rst", rd, 32'h0);

      // Zero wait states, back-to-back transfers
      bus_idle(2);
      apb_xfer(1'b1, 1'b1, 32'h08, 32'h0000_0808, rd, er, wt);
      check("fast_wr08_waits", 32'(wt), 32'd0);
      check("fast_wr08_err", {31'h0, er}, 32'h0);
      apb_xfer(1'b1, 1'b1, 32'h0C, 32'h0C0C_0C0C, rd, er, wt);
      check("fast_wr0c_waits", 32'(wt), 32'd0);
      apb_xfer(1'b1, 1'b0, 32'h08, 32'h0, rd, er, wt);
      check("fast_rd08", rd, 32'h0000_0808);
      check("fast_rd08_waits", 32'(wt), 32'd0);
      apb_xfer(1'b1, 1'b0, 32'h0C, 32'h0, rd, er, wt);
      check("fast_rd0c", rd, 32'h0C0C_0C0C);
      bus_idle(1);
      @(negedge clk);
      check("fast_idle_pready", {31'h0, pready_f}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of 2, 2..256).
REQ-002 SHALL have parameter WAIT_STATES, default 1, number of PREADY-low access-phase cycles per transfer (0..15).
REQ-003 SHALL have parameter ID_VALUE, default 32'hA5B0_0001, read-only content of register 0.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 PCLK  input  1  clock; all state updates on rising edge.
REQ-006 PRESET  input  1  synchronous, active-high reset.
REQ-007 PADDR  input  32  byte address from the requester.
REQ-008 PSELx  input  1  slave select.
REQ-009 PENABLE  input  1  access-phase indicator.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PWDATA  input  32  write data.
REQ-012 PREADY  output  1  transfer completes in the current cycle.
REQ-013 PRDATA  output  32  read data, valid only while PREADY=1 on a read.
REQ-014 PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-015 The FSM SHALL have two states: IDLE and ACCESS.
REQ-016 In IDLE with PSELx=1 and PENABLE=0 (setup phase), the block SHALL latch PADDR, PWRITE and PWDATA, load wait counter cnt=WAIT_STATES, and go to ACCESS.
REQ-017 In IDLE, every other input combination SHALL leave the block in IDLE, with no register change.
REQ-018 In ACCESS with PSELx=1, PENABLE=1 and cnt!=0, the block SHALL decrement cnt by 1 and stay in ACCESS.
REQ-019 PREADY SHALL be decoded from registered state: 1 iff state=ACCESS and cnt=0; no combinational path from inputs.
REQ-020 Each transfer SHALL see exactly WAIT_STATES access-phase cycles with PREADY=0, then one cycle with PREADY=1; WAIT_STATES=0 gives PREADY=1 in the first access cycle.
REQ-021 In ACCESS with PSELx=1, PENABLE=1 and cnt=0, the transfer SHALL complete at that edge and the FSM SHALL return to IDLE.
REQ-022 A back-to-back transfer's setup phase SHALL be accepted in the cycle after completion.
REQ-023 Address decode SHALL use the latched address; index = addr[log2(NUM_REGS)+1:2].
REQ-024 An error SHALL be flagged when addr[1:0]!=0, when addr >= 4*NUM_REGS, or on a write to index 0.
REQ-025 PSLVERR SHALL equal PREADY AND error; it SHALL be 0 whenever PREADY=0.
REQ-026 A write SHALL commit the latched PWDATA to regs[index] only at the completing edge, and only with no error.
REQ-027 An erroring write SHALL leave all registers unchanged.
REQ-028 PRDATA SHALL be regs[index] (ID_VALUE for index 0) while PREADY=1, a read is in progress and there is no error; otherwise PRDATA SHALL be 32'h0.
REQ-029 A read SHALL have no side effects.
REQ-030 If PSELx=0 or PENABLE=0 while in ACCESS (protocol violation), the block SHALL abort to IDLE with no register write.
REQ-031 An abort in which PSELx=1 and PENABLE=0 SHALL be treated as a new setup phase (REQ-016 applies).
REQ-032 PWDATA, PADDR and PWRITE changes during ACCESS SHALL be ignored; latched values apply.

Reset
REQ-033 On PRESET=1 at a rising PCLK edge: state=IDLE, cnt=0, and regs[1..NUM_REGS-1]=32'h0.
REQ-034 During and after reset: PREADY=0, PRDATA=0, PSLVERR=0.
REQ-035 Reset SHALL take priority over every other event, including a transfer that is mid-wait or completing in the same cycle; that write SHALL NOT commit.

Verification
REQ-036 Write 0x1234_5678 to 0x04, then read 0x04 (WAIT_STATES=1) -> each transfer shows one PREADY=0 access cycle; read returns 0x1234_5678 with PSLVERR=0.
REQ-037 Read 0x00 -> PRDATA=0xA5B0_0001; write 0xFFFF_FFFF to 0x00 -> PSLVERR=1; re-read -> 0xA5B0_0001.
REQ-038 Read 0x40 and write 0x06 (NUM_REGS=16) -> PSLVERR=1, PRDATA=0, no register changes.
REQ-039 WAIT_STATES=0, back-to-back writes to 0x08 then 0x0C -> PREADY=1 in the first access cycle of each; both values read back.
REQ-040 Assert PRESET during the wait cycle of a write to 0x04 -> next cycle PREADY=0; reading 0x04 returns 0.
REQ-041 Drop PSELx mid-wait on a write to 0x08 -> no commit, FSM in IDLE; a following normal read of 0x08 returns the prior value.
